// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: stage-slot payload,
// bubble constant, FSM states and the source-match helper.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned CNT_W_DEF = 16;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } stage_slot_t;

  localparam stage_slot_t BUBBLE = '0;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } hz_state_e;

  // True when an operand is actually read and names the given register
  function automatic logic src_hits(input logic              uses,
                                    input logic [REG_AW-1:0] src,
                                    input logic [REG_AW-1:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage request and hazard/forwarding-tag response bundle between the
// pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_uses_rs_i;
  logic              id_uses_rt_i;
  logic [REG_AW-1:0] id_dst_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              branch_taken_i;
  logic              mem_busy_i;

  logic              stall_pc_o;
  logic              stall_ifid_o;
  logic              flush_ifid_o;
  logic [REG_AW-1:0] RSaddr_IDEX_o;
  logic [REG_AW-1:0] RTaddr_IDEX_o;
  logic [REG_AW-1:0] WriteReg_EXMEM_o;
  logic [REG_AW-1:0] WriteReg_MEMWB_o;
  logic              RegWrite_MEM;
  logic              RegWrite_WB;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
           id_dst_i, id_regwrite_i, id_memread_i, branch_taken_i, mem_busy_i,
    input  stall_pc_o, stall_ifid_o, flush_ifid_o, RSaddr_IDEX_o,
           RTaddr_IDEX_o, WriteReg_EXMEM_o, WriteReg_MEMWB_o, RegWrite_MEM,
           RegWrite_WB, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
           id_dst_i, id_regwrite_i, id_memread_i, branch_taken_i, mem_busy_i,
    output stall_pc_o, stall_ifid_o, flush_ifid_o, RSaddr_IDEX_o,
           RTaddr_IDEX_o, WriteReg_EXMEM_o, WriteReg_MEMWB_o, RegWrite_MEM,
           RegWrite_WB, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on i_inc, sticks at all-ones,
// clears on reset.
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Tracks EX/MEM/WB stage slots, publishes forwarding tags, and raises
// load-use stall, taken-branch flush and memory-wait freeze controls.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic                   clk_i,
  input logic                   rst_i,
  pipeline_hazard_ctrl_if.slave hz
);

  stage_slot_t r_ex;
  stage_slot_t r_mem;
  stage_slot_t r_wb;
  stage_slot_t w_id_slot;
  stage_slot_t w_ex_nxt;
  hz_state_e   r_state;
  hz_state_e   w_state_nxt;

  logic w_load_use;
  logic w_run_stall;
  logic w_run_flush;
  logic w_advance;
  logic w_stall;
  logic w_flush;
  logic w_stall_evt;
  logic w_flush_evt;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;
  logic w_unused_wb;

  // ID instruction as it would be captured into EX
  always_comb begin
    w_id_slot          = BUBBLE;
    w_id_slot.valid    = hz.id_valid_i;
    w_id_slot.rs       = hz.id_rs_i;
    w_id_slot.rt       = hz.id_rt_i;
    w_id_slot.dst      = hz.id_dst_i;
    w_id_slot.regwrite = hz.id_regwrite_i;
    w_id_slot.memread  = hz.id_memread_i;
  end

  // A load writing r0 never stalls its consumer
  assign w_load_use = hz.id_valid_i & r_ex.valid & r_ex.memread &
                      (r_ex.dst != '0) &
                      (src_hits(hz.id_uses_rs_i, hz.id_rs_i, r_ex.dst) |
                       src_hits(hz.id_uses_rt_i, hz.id_rt_i, r_ex.dst));

  // Non-frozen cycle: flush outranks load-use since the stalled op is discarded
  always_comb begin
    w_ex_nxt    = w_id_slot;
    w_run_flush = 1'b0;
    w_run_stall = 1'b0;
    if (hz.branch_taken_i) begin
      w_ex_nxt    = BUBBLE;
      w_run_flush = 1'b1;
    end else if (w_load_use) begin
      w_ex_nxt    = BUBBLE;
      w_run_stall = 1'b1;
    end
  end

  // Next state and per-cycle pipeline controls
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      RUN: begin
        if (hz.mem_busy_i) begin
          w_state_nxt = FREEZE;
          w_stall     = 1'b1;
        end else begin
          w_advance = 1'b1;
          w_stall   = w_run_stall;
          w_flush   = w_run_flush;
        end
      end
      FREEZE: begin
        if (hz.mem_busy_i) begin
          w_stall = 1'b1;
        end else begin
          w_state_nxt = RUN;
          w_advance   = 1'b1;
          w_stall     = w_run_stall;
          w_flush     = w_run_flush;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_stall_evt = w_advance & w_run_stall;
  assign w_flush_evt = w_advance & w_run_flush;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= RUN;
      r_ex    <= BUBBLE;
      r_mem   <= BUBBLE;
      r_wb    <= BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_advance) begin
        r_wb  <= r_mem;
        r_mem <= r_ex;
        r_ex  <= w_ex_nxt;
      end
    end
  end

  hazard_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_inc (w_stall_evt),
    .o_cnt (w_stall_cnt)
  );

  hazard_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_inc (w_flush_evt),
    .o_cnt (w_flush_cnt)
  );

  // Controls are held low while reset is asserted, whatever the inputs do
  assign hz.stall_pc_o       = w_stall & rst_i;
  assign hz.stall_ifid_o     = w_stall & rst_i;
  assign hz.flush_ifid_o     = w_flush & rst_i;
  assign hz.RSaddr_IDEX_o    = r_ex.rs;
  assign hz.RTaddr_IDEX_o    = r_ex.rt;
  assign hz.WriteReg_EXMEM_o = r_mem.dst;
  assign hz.WriteReg_MEMWB_o = r_wb.dst;
  assign hz.RegWrite_MEM     = r_mem.valid & r_mem.regwrite;
  assign hz.RegWrite_WB      = r_wb.valid & r_wb.regwrite;
  assign hz.stall_cnt_o      = w_stall_cnt;
  assign hz.flush_cnt_o      = w_flush_cnt;

  assign w_unused_wb = ^{r_wb.rs, r_wb.rt, r_wb.memread};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, freeze / reset /
// saturation sequences, then random traffic against a queue-based model.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  bus2 ();

  pipeline_hazard_ctrl #(.CNT_W(16)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (bus1)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_dut_small (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (bus2)
  );

  typedef struct {
    int v, rs, rt, urs, urt, dst, rw, mr, br, busy;
    int spc, sif, fl, exmem, memwb, rwm, rww, scnt, fcnt;
  } vec_t;

  typedef struct {
    bit v;
    int rs, rt, dst;
    bit rw, mr;
  } mslot_t;

  vec_t   tbl [18];
  mslot_t pipe [$];
  int     m_scnt, m_fcnt;

  function automatic vec_t mk(int v, int rs, int rt, int urs, int urt, int dst,
                              int rw, int mr, int br, int busy, int spc, int sif,
                              int fl, int exmem, int memwb, int rwm, int rww,
                              int scnt, int fcnt);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.dst = dst;
    t.rw = rw; t.mr = mr; t.br = br; t.busy = busy; t.spc = spc; t.sif = sif;
    t.fl = fl; t.exmem = exmem; t.memwb = memwb; t.rwm = rwm; t.rww = rww;
    t.scnt = scnt; t.fcnt = fcnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit to2, input int v, input int rs, input int rt,
                       input int urs, input int urt, input int dst, input int rw,
                       input int mr, input int br, input int busy);
    bus1.id_valid_i     = 1'(v);
    bus1.id_rs_i        = 5'(rs);
    bus1.id_rt_i        = 5'(rt);
    bus1.id_uses_rs_i   = 1'(urs);
    bus1.id_uses_rt_i   = 1'(urt);
    bus1.id_dst_i       = 5'(dst);
    bus1.id_regwrite_i  = 1'(rw);
    bus1.id_memread_i   = 1'(mr);
    bus1.branch_taken_i = 1'(br);
    bus1.mem_busy_i     = 1'(busy);
    if (to2) begin
      bus2.id_valid_i     = 1'(v);
      bus2.id_rs_i        = 5'(rs);
      bus2.id_rt_i        = 5'(rt);
      bus2.id_uses_rs_i   = 1'(urs);
      bus2.id_uses_rt_i   = 1'(urt);
      bus2.id_dst_i       = 5'(dst);
      bus2.id_regwrite_i  = 1'(rw);
      bus2.id_memread_i   = 1'(mr);
      bus2.branch_taken_i = 1'(br);
      bus2.mem_busy_i     = 1'(busy);
    end
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, ".stall_pc"},   32'(bus1.stall_pc_o), 0);
    chk({tag, ".stall_ifid"}, 32'(bus1.stall_ifid_o), 0);
    chk({tag, ".flush_ifid"}, 32'(bus1.flush_ifid_o), 0);
    chk({tag, ".rs_idex"},    32'(bus1.RSaddr_IDEX_o), 0);
    chk({tag, ".rt_idex"},    32'(bus1.RTaddr_IDEX_o), 0);
    chk({tag, ".wr_exmem"},   32'(bus1.WriteReg_EXMEM_o), 0);
    chk({tag, ".wr_memwb"},   32'(bus1.WriteReg_MEMWB_o), 0);
    chk({tag, ".rw_mem"},     32'(bus1.RegWrite_MEM), 0);
    chk({tag, ".rw_wb"},      32'(bus1.RegWrite_WB), 0);
    chk({tag, ".stall_cnt"},  32'(bus1.stall_cnt_o), 0);
    chk({tag, ".flush_cnt"},  32'(bus1.flush_cnt_o), 0);
  endtask

  // Leaves the bench at posedge+1 with reset released and inputs idle
  task automatic do_reset(input bit check);
    rst_n = 1'b0;
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check) chk_zero1("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    mslot_t b;
    b = '{default: 0};
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(b);
    m_scnt = 0;
    m_fcnt = 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    // v rs rt urs urt dst rw mr br busy | spc sif fl exmem memwb rwm rww scnt fcnt
    tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 2, 0, 1, 0,  8, 1, 1, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 8, 1, 1, 1,  9, 1, 0, 0, 0,  1, 1, 0,  0,  0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 8, 1, 1, 1,  9, 1, 0, 0, 0,  0, 0, 0,  8,  0, 1, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  8, 0, 1, 1, 0);
    tbl[5]  = mk(1, 1, 2, 1, 1,  3, 1, 0, 0, 0,  0, 0, 0,  9,  0, 1, 0, 1, 0);
    tbl[6]  = mk(1, 4, 5, 1, 1,  6, 1, 0, 0, 0,  0, 0, 0,  0,  9, 0, 1, 1, 0);
    tbl[7]  = mk(1, 4, 5, 1, 1,  7, 1, 0, 0, 0,  0, 0, 0,  3,  0, 1, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  6,  3, 1, 1, 1, 0);
    tbl[9]  = mk(1, 1, 0, 1, 0,  0, 1, 1, 0, 0,  0, 0, 0,  7,  6, 1, 1, 1, 0);
    tbl[10] = mk(1, 0, 0, 1, 1, 10, 1, 0, 0, 0,  0, 0, 0,  0,  7, 0, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 0, 1, 0);
    tbl[12] = mk(1, 2, 0, 1, 0,  8, 1, 1, 0, 0,  0, 0, 0, 10,  0, 1, 1, 1, 0);
    tbl[13] = mk(1, 1, 8, 1, 1,  9, 1, 0, 1, 0,  0, 0, 1,  0, 10, 0, 1, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  8,  0, 1, 0, 1, 1);
    tbl[15] = mk(1, 1, 0, 1, 0,  5, 1, 1, 0, 0,  0, 0, 0,  0,  8, 0, 1, 1, 1);
    tbl[16] = mk(1, 1, 5, 1, 0, 11, 1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 1);
    tbl[17] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  5,  0, 1, 0, 1, 1);

    do_reset(1'b1);

    // Directed table: load-use, r0 load, branch-over-load-use, tag progression
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
            tbl[i].dst, tbl[i].rw, tbl[i].mr, tbl[i].br, tbl[i].busy);
      @(negedge clk);
      chk($sformatf("tbl%0d.stall_pc", i),   32'(bus1.stall_pc_o),       tbl[i].spc);
      chk($sformatf("tbl%0d.stall_ifid", i), 32'(bus1.stall_ifid_o),     tbl[i].sif);
      chk($sformatf("tbl%0d.flush_ifid", i), 32'(bus1.flush_ifid_o),     tbl[i].fl);
      chk($sformatf("tbl%0d.wr_exmem", i),   32'(bus1.WriteReg_EXMEM_o), tbl[i].exmem);
      chk($sformatf("tbl%0d.wr_memwb", i),   32'(bus1.WriteReg_MEMWB_o), tbl[i].memwb);
      chk($sformatf("tbl%0d.rw_mem", i),     32'(bus1.RegWrite_MEM),     tbl[i].rwm);
      chk($sformatf("tbl%0d.rw_wb", i),      32'(bus1.RegWrite_WB),      tbl[i].rww);
      chk($sformatf("tbl%0d.stall_cnt", i),  32'(bus1.stall_cnt_o),      tbl[i].scnt);
      chk($sformatf("tbl%0d.flush_cnt", i),  32'(bus1.flush_cnt_o),      tbl[i].fcnt);
      @(posedge clk);
      #1;
    end

    // Memory freeze with a branch pulse inside it, branch re-presented on release
    do_reset(1'b0);
    drive(1'b0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(1'b0, 1, 6, 7, 1, 1, 4, 1, 0, 0, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1, 1, 2, 1, 1, 5, 1, 0, (c == 1) ? 1 : 0, 1);
      @(negedge clk);
      chk($sformatf("frz%0d.stall_pc", c),   32'(bus1.stall_pc_o), 1);
      chk($sformatf("frz%0d.stall_ifid", c), 32'(bus1.stall_ifid_o), 1);
      chk($sformatf("frz%0d.flush_ifid", c), 32'(bus1.flush_ifid_o), 0);
      chk($sformatf("frz%0d.wr_exmem", c),   32'(bus1.WriteReg_EXMEM_o), 3);
      chk($sformatf("frz%0d.wr_memwb", c),   32'(bus1.WriteReg_MEMWB_o), 0);
      chk($sformatf("frz%0d.rs_idex", c),    32'(bus1.RSaddr_IDEX_o), 6);
      chk($sformatf("frz%0d.flush_cnt", c),  32'(bus1.flush_cnt_o), 0);
      @(posedge clk); #1;
    end
    drive(1'b0, 1, 1, 2, 1, 1, 5, 1, 0, 1, 0);
    @(negedge clk);
    chk("rel.flush_ifid", 32'(bus1.flush_ifid_o), 1);
    chk("rel.stall_pc",   32'(bus1.stall_pc_o), 0);
    chk("rel.wr_exmem",   32'(bus1.WriteReg_EXMEM_o), 3);
    chk("rel.rs_idex",    32'(bus1.RSaddr_IDEX_o), 6);
    @(posedge clk); #1;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post.wr_exmem",  32'(bus1.WriteReg_EXMEM_o), 4);
    chk("post.wr_memwb",  32'(bus1.WriteReg_MEMWB_o), 3);
    chk("post.rw_wb",     32'(bus1.RegWrite_WB), 1);
    chk("post.rs_idex",   32'(bus1.RSaddr_IDEX_o), 0);
    chk("post.flush_cnt", 32'(bus1.flush_cnt_o), 1);
    chk("post.stall_cnt", 32'(bus1.stall_cnt_o), 0);
    @(posedge clk); #1;

    // Self-dependent load stream: one stall every two cycles, saturate the 4-bit copy
    do_reset(1'b0);
    drive(1'b1, 1, 8, 0, 1, 0, 8, 1, 1, 0, 0);
    repeat (28) @(posedge clk);
    @(negedge clk);
    chk("sat28.cnt16", 32'(bus1.stall_cnt_o), 14);
    chk("sat28.cnt4",  32'(bus2.stall_cnt_o), 14);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("sat40.cnt16", 32'(bus1.stall_cnt_o), 20);
    chk("sat40.cnt4",  32'(bus2.stall_cnt_o), 15);
    @(posedge clk);
    @(negedge clk);
    chk("midstall.stall_pc16", 32'(bus1.stall_pc_o), 1);
    chk("midstall.stall_pc4",  32'(bus2.stall_pc_o), 1);
    chk("midstall.cnt4",       32'(bus2.stall_cnt_o), 15);
    rst_n = 1'b0;
    #1;
    chk_zero1("rst_mid");
    chk("rst_mid.cnt4",      32'(bus2.stall_cnt_o), 0);
    chk("rst_mid.stall_pc4", 32'(bus2.stall_pc_o), 0);
    chk("rst_mid.rw_mem4",   32'(bus2.RegWrite_MEM), 0);
    @(posedge clk); #1;
    drive(1'b1, 1, 4, 5, 1, 1, 6, 1, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst.stall_pc", 32'(bus1.stall_pc_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_rst.rs_idex", 32'(bus1.RSaddr_IDEX_o), 4);
    chk("after_rst.rt_idex", 32'(bus1.RTaddr_IDEX_o), 5);
    chk("after_rst.cnt16",   32'(bus1.stall_cnt_o), 0);
    @(posedge clk); #1;

    // Random traffic against the reference model
    do_reset(1'b0);
    model_reset();
    for (int n = 0; n < 400; n++) begin
      int v, rs, rt, urs, urt, dst, rw, mr, br, busy;
      bit lu, e_stall, e_flush;
      mslot_t ex, nw;
      rst_n = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      v    = ($urandom_range(99) < 85) ? 1 : 0;
      rs   = $urandom_range(3);
      rt   = $urandom_range(3);
      urs  = ($urandom_range(99) < 80) ? 1 : 0;
      urt  = ($urandom_range(99) < 60) ? 1 : 0;
      dst  = $urandom_range(3);
      rw   = ($urandom_range(99) < 70) ? 1 : 0;
      mr   = ($urandom_range(99) < 40) ? 1 : 0;
      br   = ($urandom_range(99) < 15) ? 1 : 0;
      busy = ($urandom_range(99) < 20) ? 1 : 0;
      drive(1'b0, v, rs, rt, urs, urt, dst, rw, mr, br, busy);
      if (!rst_n) model_reset();
      ex = pipe[0];
      lu = (v != 0) && ex.v && ex.mr && (ex.dst != 0) &&
           (((urs != 0) && (rs == ex.dst)) || ((urt != 0) && (rt == ex.dst)));
      e_stall = rst_n && ((busy != 0) || ((br == 0) && lu));
      e_flush = rst_n && (busy == 0) && (br != 0);
      @(negedge clk);
      chk("rnd.stall_pc",   32'(bus1.stall_pc_o),       32'(e_stall));
      chk("rnd.stall_ifid", 32'(bus1.stall_ifid_o),     32'(e_stall));
      chk("rnd.flush_ifid", 32'(bus1.flush_ifid_o),     32'(e_flush));
      chk("rnd.rs_idex",    32'(bus1.RSaddr_IDEX_o),    pipe[0].rs);
      chk("rnd.rt_idex",    32'(bus1.RTaddr_IDEX_o),    pipe[0].rt);
      chk("rnd.wr_exmem",   32'(bus1.WriteReg_EXMEM_o), pipe[1].dst);
      chk("rnd.wr_memwb",   32'(bus1.WriteReg_MEMWB_o), pipe[2].dst);
      chk("rnd.rw_mem",     32'(bus1.RegWrite_MEM),     32'(pipe[1].v && pipe[1].rw));
      chk("rnd.rw_wb",      32'(bus1.RegWrite_WB),      32'(pipe[2].v && pipe[2].rw));
      chk("rnd.stall_cnt",  32'(bus1.stall_cnt_o),      m_scnt);
      chk("rnd.flush_cnt",  32'(bus1.flush_cnt_o),      m_fcnt);
      if (rst_n && (busy == 0)) begin
        if ((br != 0) || lu) begin
          nw = '{default: 0};
        end else begin
          nw = '{v: (v != 0), rs: rs, rt: rt, dst: dst, rw: (rw != 0), mr: (mr != 0)};
        end
        pipe.push_front(nw);
        void'(pipe.pop_back());
        if (br != 0) m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : m_fcnt;
        else if (lu) m_scnt = (m_scnt < 65535) ? m_scnt + 1 : m_scnt;
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
